am2911_nac: RTL and testbench

Registered next-address control unit that drives a cascade of 4-bit microprogram sequencer slices. It latches the opcode and branch/count field of each microinstruction into an internal pipeline register. It decodes them against a live condition input to produce the slice controls s, fe_, pup, zero_ and re_, plus the din-source enables. It also keeps the loop counter and a logical stack-depth tracker that mirrors the slices' 4-deep circular stack.

---
 rtl/am2911_nac_if.sv | 43 ++++
 rtl/am2911_nac.sv | 255 +++++++++++++++++++++++++
 tb/tb_am2911_nac.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/am2911_nac_if.sv
// ---------------------------------------------------------------------------
// am2911_nac_if
//   Bundle of the next-address controller's data/control signals.
//   master : drives opcode i, count field d, ccen_ and test, observes outputs
//   slave  : the controller itself (samples i/d, drives slice controls)
//   Signals:
//     i[3:0], d[CWIDTH-1:0]          microinstruction opcode and count field
//     ccen_, test                    live condition inputs (pass = ccen_ | test)
//     s[1:0], fe_, pup, zero_, re_   slice controls
//     pl_oe_, map_oe_, vect_oe_      active-low din-source enables
//     cnt_zero, full, empty, ovf, unf  counter / stack-depth status
// ---------------------------------------------------------------------------
interface am2911_nac_if #(parameter int CWIDTH = 12);
    logic [3:0]        i;
    logic [CWIDTH-1:0] d;
    logic              ccen_;
    logic              test;
    logic [1:0]        s;
    logic              fe_;
    logic              pup;
    logic              zero_;
    logic              re_;
    logic              pl_oe_;
    logic              map_oe_;
    logic              vect_oe_;
    logic              cnt_zero;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    modport master (
        output i, d, ccen_, test,
        input  s, fe_, pup, zero_, re_, pl_oe_, map_oe_, vect_oe_,
               cnt_zero, full, empty, ovf, unf
    );

    modport slave (
        input  i, d, ccen_, test,
        output s, fe_, pup, zero_, re_, pl_oe_, map_oe_, vect_oe_,
               cnt_zero, full, empty, ovf, unf
    );
endinterface

// File: rtl/am2911_nac.sv
// ---------------------------------------------------------------------------
// am2911_nac
//   Next-address control unit for a cascade of 4-bit microprogram sequencer
//   slices. Pipelines {opcode, count field}, decodes it against the live
//   condition into slice controls, and tracks the loop counter and the
//   logical depth of the slices' 4-deep circular stack.
//   Ports:
//     cp   : clock, state updates on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : am2911_nac_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module am2911_nac #(
    parameter int CWIDTH = 12
) (
    input  logic         cp,
    input  logic         rst,
    am2911_nac_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,  OP_CJS  = 4'd1,  OP_JMAP = 4'd2,  OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,  OP_JSRP = 4'd5,  OP_CJV  = 4'd6,  OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,  OP_RPCT = 4'd9,  OP_CRTN = 4'd10, OP_CJPP = 4'd11,
        OP_LDCT = 4'd12, OP_LOOP = 4'd13, OP_CONT = 4'd14, OP_TWB  = 4'd15
    } op_e;

    localparam logic [1:0] SRC_UPC = 2'b00;
    localparam logic [1:0] SRC_REG = 2'b01;
    localparam logic [1:0] SRC_STK = 2'b10;
    localparam logic [1:0] SRC_DIN = 2'b11;

    // Pipeline and bookkeeping state
    op_e               op_q;
    logic [CWIDTH-1:0] dq_q;
    logic [CWIDTH-1:0] cnt_q,   cnt_d;
    logic [2:0]        depth_q, depth_d;
    logic              ovf_q,   ovf_d;
    logic              unf_q,   unf_d;

    // Decoded actions
    logic       pass_s;
    logic       cnz_s;
    logic [1:0] s_s;
    logic       push_s, pop_s, ld_s, dec_s, clr_s;
    logic       pl_oe_s, map_oe_s, vect_oe_s;

    assign pass_s = bus.ccen_ | bus.test;
    assign cnz_s  = (cnt_q != {CWIDTH{1'b0}});

    // Opcode decode: source select, stack action, counter action, din enable
    always_comb begin
        s_s       = SRC_UPC;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ld_s      = 1'b0;
        dec_s     = 1'b0;
        clr_s     = 1'b0;
        pl_oe_s   = 1'b1;
        map_oe_s  = 1'b1;
        vect_oe_s = 1'b1;
        case (op_q)
            OP_JZ: begin
                clr_s = 1'b1;
            end
            OP_CJS: begin
                if (pass_s) begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                    push_s  = 1'b1;
                end else begin
                    s_s = SRC_UPC;
                end
            end
            OP_JMAP: begin
                s_s      = SRC_DIN;
                map_oe_s = 1'b0;
            end
            OP_CJP: begin
                if (pass_s) begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                end else begin
                    s_s = SRC_UPC;
                end
            end
            OP_PUSH: begin
                push_s = 1'b1;
                if (pass_s) begin
                    ld_s = 1'b1;
                end else begin
                    ld_s = 1'b0;
                end
            end
            OP_JSRP: begin
                push_s = 1'b1;
                if (pass_s) begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                end else begin
                    s_s = SRC_REG;
                end
            end
            OP_CJV: begin
                if (pass_s) begin
                    s_s       = SRC_DIN;
                    vect_oe_s = 1'b0;
                end else begin
                    s_s = SRC_UPC;
                end
            end
            OP_JRP: begin
                if (pass_s) begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                end else begin
                    s_s = SRC_REG;
                end
            end
            OP_RFCT: begin
                if (cnz_s) begin
                    s_s   = SRC_STK;
                    dec_s = 1'b1;
                end else begin
                    pop_s = 1'b1;
                end
            end
            OP_RPCT: begin
                if (cnz_s) begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                    dec_s   = 1'b1;
                end else begin
                    s_s = SRC_UPC;
                end
            end
            OP_CRTN: begin
                if (pass_s) begin
                    s_s   = SRC_STK;
                    pop_s = 1'b1;
                end else begin
                    s_s = SRC_UPC;
                end
            end
            OP_CJPP: begin
                if (pass_s) begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                    pop_s   = 1'b1;
                end else begin
                    s_s = SRC_UPC;
                end
            end
            OP_LDCT: begin
                ld_s = 1'b1;
            end
            OP_LOOP: begin
                if (pass_s) begin
                    pop_s = 1'b1;
                end else begin
                    s_s = SRC_STK;
                end
            end
            OP_CONT: begin
                s_s = SRC_UPC;
            end
            OP_TWB: begin
                // Pass exits the loop; on fail, count down while the counter
                // lasts, then fall out through the pipeline address.
                if (pass_s) begin
                    pop_s = 1'b1;
                end else if (cnz_s) begin
                    s_s   = SRC_STK;
                    dec_s = 1'b1;
                end else begin
                    s_s     = SRC_DIN;
                    pl_oe_s = 1'b0;
                    pop_s   = 1'b1;
                end
            end
            default: begin
                s_s = SRC_UPC;
            end
        endcase
    end

    // Next-state for counter, stack depth and sticky flags
    always_comb begin
        cnt_d   = cnt_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        // Load wins; decrement is only decoded with a nonzero count.
        if (ld_s) begin
            cnt_d = dq_q;
        end else if (dec_s) begin
            cnt_d = cnt_q - CWIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (clr_s) begin
            depth_d = 3'd0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (push_s) begin
            // The slice stack wraps on overflow, so depth stays at 4.
            if (depth_q == 3'd4) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 3'd1;
            end
        end else if (pop_s) begin
            if (depth_q == 3'd0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - 3'd1;
            end
        end else begin
            depth_d = depth_q;
        end
    end

    // Pipeline register and bookkeeping state
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            op_q    <= OP_JZ;
            dq_q    <= {CWIDTH{1'b0}};
            cnt_q   <= {CWIDTH{1'b0}};
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            op_q    <= op_e'(bus.i);
            dq_q    <= bus.d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.s        = s_s;
    assign bus.fe_      = ~(push_s | pop_s);
    assign bus.pup      = push_s;
    assign bus.zero_    = ~clr_s;
    assign bus.re_      = ~ld_s;
    assign bus.pl_oe_   = pl_oe_s;
    assign bus.map_oe_  = map_oe_s;
    assign bus.vect_oe_ = vect_oe_s;
    assign bus.cnt_zero = ~cnz_s;
    assign bus.full     = (depth_q == 3'd4);
    assign bus.empty    = (depth_q == 3'd0);
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

endmodule

// File: tb/tb_am2911_nac.sv
// ---------------------------------------------------------------------------
// tb_am2911_nac
//   Directed bench for am2911_nac. A behavioural model (action table per
//   opcode, integer counter/depth) predicts every output each cycle; literal
//   checks pin the scenarios of interest.
// ---------------------------------------------------------------------------
module tb_am2911_nac;
    localparam int CW   = 12;
    localparam int MASK = (1 << CW) - 1;

    // Abstract next-address sources
    localparam int A_UPC = 0, A_REG = 1, A_STK = 2, A_PL = 3, A_MAP = 4, A_VEC = 5;
    // Stack actions
    localparam int K_NONE = 0, K_PUSH = 1, K_POP = 2;

    logic cp;
    logic rst;
    int   checks;
    int   failures;

    am2911_nac_if #(.CWIDTH(CW)) bus ();

    am2911_nac #(.CWIDTH(CW)) dut (
        .cp  (cp),
        .rst (rst),
        .bus (bus)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        int src;
        int stk;
        bit ld;
        bit dec;
        bit jz;
    } act_t;

    // Model state
    int m_op, m_dq, m_cnt, m_depth;
    bit m_ovf, m_unf;

    function automatic act_t decode(int op, bit pass, int cnt);
        act_t a;
        a.src = A_UPC; a.stk = K_NONE; a.ld = 0; a.dec = 0; a.jz = 0;
        case (op)
            0:  a.jz = 1;
            1:  if (pass) begin a.src = A_PL; a.stk = K_PUSH; end
            2:  a.src = A_MAP;
            3:  if (pass) a.src = A_PL;
            4:  begin a.stk = K_PUSH; a.ld = pass; end
            5:  begin a.stk = K_PUSH; a.src = pass ? A_PL : A_REG; end
            6:  if (pass) a.src = A_VEC;
            7:  a.src = pass ? A_PL : A_REG;
            8:  if (cnt != 0) begin a.src = A_STK; a.dec = 1; end else a.stk = K_POP;
            9:  if (cnt != 0) begin a.src = A_PL; a.dec = 1; end
            10: if (pass) begin a.src = A_STK; a.stk = K_POP; end
            11: if (pass) begin a.src = A_PL; a.stk = K_POP; end
            12: a.ld = 1;
            13: if (pass) a.stk = K_POP; else a.src = A_STK;
            14: ;
            15: if (pass) a.stk = K_POP;
                else if (cnt != 0) begin a.src = A_STK; a.dec = 1; end
                else begin a.src = A_PL; a.stk = K_POP; end
            default: ;
        endcase
        return a;
    endfunction

    // Expected output vector {s,fe_,pup,zero_,re_,pl,map,vect,cz,full,empty,ovf,unf}
    function automatic logic [14:0] expect_vec(act_t a);
        logic [1:0] s;
        logic pl, mp, vc;
        s = 2'b00; pl = 1'b1; mp = 1'b1; vc = 1'b1;
        case (a.src)
            A_REG: s = 2'b01;
            A_STK: s = 2'b10;
            A_PL:  begin s = 2'b11; pl = 1'b0; end
            A_MAP: begin s = 2'b11; mp = 1'b0; end
            A_VEC: begin s = 2'b11; vc = 1'b0; end
            default: s = 2'b00;
        endcase
        return {s, (a.stk == K_NONE) ? 1'b1 : 1'b0, (a.stk == K_PUSH) ? 1'b1 : 1'b0,
                ~a.jz, ~a.ld, pl, mp, vc, (m_cnt == 0) ? 1'b1 : 1'b0,
                (m_depth == 4) ? 1'b1 : 1'b0, (m_depth == 0) ? 1'b1 : 1'b0, m_ovf, m_unf};
    endfunction

    // Model state update at each rising edge, reset asynchronously
    always @(posedge cp or posedge rst) begin
        act_t a;
        if (rst) begin
            m_op = 0; m_dq = 0; m_cnt = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
        end else begin
            a = decode(m_op, bus.ccen_ | bus.test, m_cnt);
            if (a.jz) begin
                m_depth = 0; m_ovf = 0; m_unf = 0;
            end else if (a.stk == K_PUSH) begin
                if (m_depth == 4) m_ovf = 1; else m_depth++;
            end else if (a.stk == K_POP) begin
                if (m_depth == 0) m_unf = 1; else m_depth--;
            end
            if (a.ld) m_cnt = m_dq;
            else if (a.dec) m_cnt = (m_cnt - 1) & MASK;
            m_op = int'(bus.i);
            m_dq = int'(bus.d);
        end
    end

    // Cycle-by-cycle compare of all outputs against the model
    always @(negedge cp) begin
        logic [14:0] exp_v, act_v;
        exp_v = expect_vec(decode(m_op, bus.ccen_ | bus.test, m_cnt));
        act_v = {bus.s, bus.fe_, bus.pup, bus.zero_, bus.re_, bus.pl_oe_, bus.map_oe_,
                 bus.vect_oe_, bus.cnt_zero, bus.full, bus.empty, bus.ovf, bus.unf};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL model_cmp t=%0t op=%0d actual=%b required=%b", $time, m_op, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Present an op for the next edge, then apply its condition inputs
    task automatic do_op(input int op, input int dv, input bit cc, input bit tt);
        bus.i = op[3:0];
        bus.d = dv[CW-1:0];
        @(posedge cp);
        #1;
        bus.ccen_ = cc;
        bus.test  = tt;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        bus.i = 4'd14; bus.d = '0; bus.ccen_ = 1'b1; bus.test = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_zero", 12'(bus.zero_), 12'd0);
        chk("rst_cz", 12'(bus.cnt_zero), 12'd1);
        chk("rst_empty", 12'(bus.empty), 12'd1);
        @(posedge cp); @(posedge cp);
        #3 rst = 1'b0;
        #1 chk("rel_jz", 12'(bus.zero_), 12'd0);

        // Condition select
        do_op(3, 0, 0, 0); chk("cjp_fail_s", 12'(bus.s), 12'd0); chk("cjp_fail_pl", 12'(bus.pl_oe_), 12'd1);
        do_op(3, 0, 0, 1); chk("cjp_pass_s", 12'(bus.s), 12'd3); chk("cjp_pass_pl", 12'(bus.pl_oe_), 12'd0);
        do_op(3, 0, 1, 0); chk("cjp_forced_s", 12'(bus.s), 12'd3);

        // Sources
        do_op(2, 0, 1, 0); chk("jmap_map", 12'(bus.map_oe_), 12'd0); chk("jmap_s", 12'(bus.s), 12'd3);
        do_op(6, 0, 1, 0); chk("cjv_vect", 12'(bus.vect_oe_), 12'd0);
        do_op(7, 0, 0, 0); chk("jrp_fail_s", 12'(bus.s), 12'd1);
        do_op(12, 12'hABC, 1, 0); chk("ldct_re", 12'(bus.re_), 12'd0);
        do_op(14, 0, 1, 0); chk("ldct_cz", 12'(bus.cnt_zero), 12'd0);

        // Loop: PUSH d=3 then four RFCT
        do_op(4, 3, 1, 0); chk("push_fe", 12'(bus.fe_), 12'd0); chk("push_re", 12'(bus.re_), 12'd0);
        do_op(8, 0, 1, 0); chk("rfct1_s", 12'(bus.s), 12'd2);
        do_op(8, 0, 1, 0); chk("rfct2_s", 12'(bus.s), 12'd2);
        do_op(8, 0, 1, 0); chk("rfct3_s", 12'(bus.s), 12'd2);
        do_op(8, 0, 1, 0); chk("rfct4_s", 12'(bus.s), 12'd0); chk("rfct4_fe", 12'(bus.fe_), 12'd0);
        chk("rfct4_cz", 12'(bus.cnt_zero), 12'd1);
        do_op(14, 0, 1, 0); chk("loop_empty", 12'(bus.empty), 12'd1);

        // TWB
        do_op(12, 2, 1, 0);
        do_op(15, 0, 0, 0); chk("twb2_s", 12'(bus.s), 12'd2);
        do_op(15, 0, 0, 0); chk("twb1_s", 12'(bus.s), 12'd2); chk("twb1_cz", 12'(bus.cnt_zero), 12'd0);
        do_op(15, 0, 0, 0); chk("twb0_s", 12'(bus.s), 12'd3); chk("twb0_pl", 12'(bus.pl_oe_), 12'd0);
        chk("twb0_fe", 12'(bus.fe_), 12'd0); chk("twb0_pup", 12'(bus.pup), 12'd0);
        do_op(15, 0, 0, 1); chk("twbp_s", 12'(bus.s), 12'd0); chk("twbp_fe", 12'(bus.fe_), 12'd0);
        chk("twb_unf", 12'(bus.unf), 12'd1);
        do_op(0, 0, 1, 0);

        // Stack limits
        for (int k = 0; k < 5; k++) do_op(1, 0, 1, 0);
        chk("cjs_full", 12'(bus.full), 12'd1);
        for (int k = 0; k < 5; k++) do_op(10, 0, 1, 0);
        chk("cjs_ovf", 12'(bus.ovf), 12'd1);
        do_op(0, 0, 1, 0); chk("crtn_unf", 12'(bus.unf), 12'd1); chk("crtn_empty", 12'(bus.empty), 12'd1);
        do_op(14, 0, 1, 0); chk("jz_ovf", 12'(bus.ovf), 12'd0); chk("jz_unf", 12'(bus.unf), 12'd0);

        // Reset mid-RFCT loop with a live counter
        do_op(12, 5, 1, 0);
        do_op(8, 0, 1, 0);
        do_op(8, 0, 1, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_zero", 12'(bus.zero_), 12'd0);
        chk("mid_cz", 12'(bus.cnt_zero), 12'd1);
        chk("mid_empty", 12'(bus.empty), 12'd1);
        chk("mid_s", 12'(bus.s), 12'd0);
        #2 rst = 1'b0;
        #1 chk("mid_rel_jz", 12'(bus.zero_), 12'd0);
        do_op(14, 0, 1, 0); chk("mid_cont", 12'(bus.zero_), 12'd1);
        do_op(14, 0, 1, 0);

        @(posedge cp);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
